// File: rtl/sys_bridge.sv
// sys_bridge: M-stage bus bridge. Decodes CPU accesses to two zero-wait
// timers and one slow handshaked device (wait states + timeout), and
// builds the 6-bit HWInt vector for CP0.
//
// Ports:
//   clk, reset (async, active-low)
//   PrAddr/PrWD/PrBE/PrWE/PrRE in, PrRD/PrStall/BusErr/HWInt out (CPU side)
//   tm0_we/tm1_we/tm_addr/tm_wd out, tm0_rd/tm1_rd/tm0_irq/tm1_irq in
//   dev_req/dev_we/dev_addr/dev_wd/dev_be out, dev_ack/dev_rd/dev_irq in
//   ext_int in (asynchronous external interrupt lines)
//
// Optional build macro BRIDGE_EXT_EDGE_EN: ext_int becomes edge-latched
// into a pending register, cleared through a write to byte 0x7F40.
module sys_bridge #(
    parameter int TIMEOUT     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic [3:0]  PrBE,
    input  logic        PrWE,
    input  logic        PrRE,
    output logic [31:0] PrRD,
    output logic        PrStall,
    output logic        BusErr,
    output logic [5:0]  HWInt,
    output logic        tm0_we,
    output logic        tm1_we,
    output logic [1:0]  tm_addr,
    output logic [31:0] tm_wd,
    input  logic [31:0] tm0_rd,
    input  logic [31:0] tm1_rd,
    input  logic        tm0_irq,
    input  logic        tm1_irq,
    output logic        dev_req,
    output logic        dev_we,
    output logic [2:0]  dev_addr,
    output logic [31:0] dev_wd,
    output logic [3:0]  dev_be,
    input  logic        dev_ack,
    input  logic [31:0] dev_rd,
    input  logic        dev_irq,
    input  logic [2:0]  ext_int
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // word-address decode
    logic tm0_hit;
    logic tm1_hit;
    logic dev_hit;

    assign tm0_hit = (PrAddr[29:2] == 28'h00007F0) && (PrAddr[1:0] != 2'd3);
    assign tm1_hit = (PrAddr[29:2] == 28'h00007F1) && (PrAddr[1:0] != 2'd3);
    assign dev_hit = (PrAddr[29:3] == 27'h00003F9);

    assign tm0_we  = PrWE & tm0_hit;
    assign tm1_we  = PrWE & tm1_hit;
    assign tm_addr = PrAddr[1:0];
    assign tm_wd   = PrWD;

    // slow-device FSM
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        launch;
    logic        fsm_stall;

    logic        lat_we;
    logic [2:0]  lat_addr;
    logic [31:0] lat_wd;
    logic [3:0]  lat_be;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        launch    = 1'b0;
        fsm_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dev_hit && (PrWE || PrRE)) begin
                    launch    = 1'b1;
                    fsm_stall = 1'b1;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    rdata_d   = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                fsm_stall = 1'b1;
                // ack beats a simultaneous expiry
                if (dev_ack) begin
                    rdata_d = lat_we ? '0 : dev_rd;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // the stalled instruction is still in M; do not relaunch
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // request fields, held stable for the whole WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            lat_be   <= '0;
        end else if (launch) begin
            lat_we   <= PrWE;
            lat_addr <= PrAddr[2:0];
            lat_wd   <= PrWD;
            lat_be   <= PrBE;
        end
    end

    assign dev_req  = (state_q == WAIT);
    assign dev_we   = lat_we;
    assign dev_addr = lat_addr;
    assign dev_wd   = lat_wd;
    assign dev_be   = lat_be;
    // IDLE stall is combinational from the bus, so mask it in reset
    assign PrStall  = reset & fsm_stall;
    assign BusErr   = (state_q == DONE) & err_q;

    // interrupt synchroniser
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] ext_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef BRIDGE_EXT_EDGE_EN
    logic       clr_hit;
    logic [2:0] clr;
    logic [2:0] rise;
    logic [2:0] pending_q;

    assign clr_hit = (PrAddr == 30'h00001FD0);
    assign clr     = (clr_hit && PrWE && PrBE[0]) ? PrWD[2:0] : 3'b000;
    // rise seen one stage early so pending lands with the level latency
    assign rise    = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr) | rise;
        end
    end

    assign ext_vec = pending_q;
`else
    assign ext_vec = sync_q[SYNC_STAGES-1];
`endif

    assign HWInt = {ext_vec, dev_irq, tm1_irq, tm0_irq};

    // read data return
    always_comb begin
        PrRD = '0;
        if (!reset) begin
            PrRD = '0;
        end else if (state_q == DONE) begin
            PrRD = rdata_q;
        end else if (PrRE && tm0_hit) begin
            PrRD = tm0_rd;
        end else if (PrRE && tm1_hit) begin
            PrRD = tm1_rd;
        end
`ifdef BRIDGE_EXT_EDGE_EN
        else if (PrRE && clr_hit) begin
            PrRD = {29'b0, pending_q};
        end
`endif
    end

endmodule

// File: tb/tb_sys_bridge.sv
// tb_sys_bridge: self-checking bench for sys_bridge.
// Vector table, directed device/interrupt sequences and randomized accesses.
module tb_sys_bridge;

    localparam int TO = 16;
    localparam int SS = 2;
    localparam logic [31:0] TM0 = 32'hAAAA_0000;
    localparam logic [31:0] TM1 = 32'hBBBB_1111;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] PrAddr;
    logic [31:0] PrWD;
    logic [3:0]  PrBE;
    logic        PrWE;
    logic        PrRE;
    logic [31:0] PrRD;
    logic        PrStall;
    logic        BusErr;
    logic [5:0]  HWInt;
    logic        tm0_we;
    logic        tm1_we;
    logic [1:0]  tm_addr;
    logic [31:0] tm_wd;
    logic [31:0] tm0_rd;
    logic [31:0] tm1_rd;
    logic        tm0_irq;
    logic        tm1_irq;
    logic        dev_req;
    logic        dev_we;
    logic [2:0]  dev_addr;
    logic [31:0] dev_wd;
    logic [3:0]  dev_be;
    logic        dev_ack;
    logic [31:0] dev_rd;
    logic        dev_irq;
    logic [2:0]  ext_int;

    always #5 clk = ~clk;

    sys_bridge #(
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .PrAddr  (PrAddr),
        .PrWD    (PrWD),
        .PrBE    (PrBE),
        .PrWE    (PrWE),
        .PrRE    (PrRE),
        .PrRD    (PrRD),
        .PrStall (PrStall),
        .BusErr  (BusErr),
        .HWInt   (HWInt),
        .tm0_we  (tm0_we),
        .tm1_we  (tm1_we),
        .tm_addr (tm_addr),
        .tm_wd   (tm_wd),
        .tm0_rd  (tm0_rd),
        .tm1_rd  (tm1_rd),
        .tm0_irq (tm0_irq),
        .tm1_irq (tm1_irq),
        .dev_req (dev_req),
        .dev_we  (dev_we),
        .dev_addr(dev_addr),
        .dev_wd  (dev_wd),
        .dev_be  (dev_be),
        .dev_ack (dev_ack),
        .dev_rd  (dev_rd),
        .dev_irq (dev_irq),
        .ext_int (ext_int)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        PrAddr = '0;
        PrWD   = '0;
        PrBE   = '0;
        PrWE   = 1'b0;
        PrRE   = 1'b0;
    endtask

    typedef struct {
        logic [31:0] baddr;
        logic        we;
        logic        re;
        logic [31:0] wd;
        logic        w0;
        logic        w1;
        logic [1:0]  ta;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] b, input logic we,
                                input logic re, input logic [31:0] wd,
                                input logic w0, input logic w1,
                                input logic [1:0] ta, input logic [31:0] rd);
        vec_t v;
        v.baddr = b;
        v.we    = we;
        v.re    = re;
        v.wd    = wd;
        v.w0    = w0;
        v.w1    = w1;
        v.ta    = ta;
        v.rd    = rd;
        return v;
    endfunction

    function automatic logic [95:0] comb_act();
        return {25'b0, tm0_we, tm1_we, tm_addr, PrStall, dev_req, BusErr,
                tm_wd, PrRD};
    endfunction

    // reference decode for non-device accesses, from byte ranges
    function automatic logic [95:0] model(input logic [31:0] b,
                                          input logic we, input logic re,
                                          input logic [31:0] wd);
        logic        h0;
        logic        h1;
        logic [31:0] rd;
        logic [31:0] off;
        h0  = (b >= 32'h7F00) && (b <= 32'h7F0B);
        h1  = (b >= 32'h7F10) && (b <= 32'h7F1B);
        rd  = 32'h0;
        if (re && h0) rd = TM0;
        else if (re && h1) rd = TM1;
        off = (b / 4) % 4;
        return {25'b0, we && h0, we && h1, off[1:0], 3'b000, wd, rd};
    endfunction

    task automatic dev_access(input logic [31:0] baddr, input logic we,
                              input logic re, input logic [31:0] wd,
                              input logic [3:0] be, input int d,
                              input logic [31:0] rdv, input string tag);
        int   n;
        int   stalls;
        logic err_exp;
        logic req_ok;
        logic lat_ok;
        err_exp = (d == 0) || (d > TO);
        n       = err_exp ? TO : d;
        stalls  = 0;
        req_ok  = 1'b1;
        lat_ok  = 1'b1;
        @(posedge clk); #1;
        PrAddr  = baddr[31:2];
        PrWE    = we;
        PrRE    = re;
        PrWD    = wd;
        PrBE    = be;
        dev_rd  = rdv;
        dev_ack = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!PrStall) break;
            stalls++;
            if (dev_req !== (c > 0)) req_ok = 1'b0;
            if (c > 0 && (dev_addr !== baddr[4:2] || dev_we !== we ||
                          dev_wd !== wd || dev_be !== be))
                lat_ok = 1'b0;
            @(posedge clk); #1;
            dev_ack = (c + 1 == d);
        end
        chk({tag, " stall cycles"}, stalls, 1 + n);
        chk({tag, " req pattern"}, req_ok, 1'b1);
        chk({tag, " latched fields"}, lat_ok, 1'b1);
        chk({tag, " done req"}, dev_req, 1'b0);
        chk({tag, " done BusErr"}, BusErr, err_exp);
        if (re && !we)
            chk({tag, " done PrRD"}, PrRD, err_exp ? 32'h0 : rdv);
        @(posedge clk); #1;
        dev_ack = 1'b0;
        bus_idle();
        @(negedge clk);
        chk({tag, " back idle"}, {BusErr, PrStall, dev_req}, 3'b000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [2:0]  hist[$];
        logic [31:0] b;
        logic        we;
        logic        re;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [2:0]  v;
        int          m;

        reset   = 1'b0;
        bus_idle();
        tm0_rd  = TM0;
        tm1_rd  = TM1;
        tm0_irq = 1'b1;
        tm1_irq = 1'b0;
        dev_irq = 1'b1;
        dev_ack = 1'b0;
        dev_rd  = '0;
        ext_int = '0;

        // reset state, with a device load presented on the bus
        PrAddr = 30'h1FC9;
        PrRE   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset outputs",
            {PrStall, BusErr, dev_req, dev_we, dev_addr, dev_wd, dev_be, PrRD},
            '0);
        chk("reset HWInt", HWInt, 6'b000101);
        @(posedge clk); #1;
        reset   = 1'b1;
        bus_idle();
        tm0_irq = 1'b0;
        dev_irq = 1'b0;

        // decode table
        tbl.push_back(mk(32'h7F04, 1, 0, 32'h64, 1, 0, 2'd1, 32'h0));
        tbl.push_back(mk(32'h7F00, 0, 1, 32'h0, 0, 0, 2'd0, TM0));
        tbl.push_back(mk(32'h7F08, 0, 1, 32'h5, 0, 0, 2'd2, TM0));
        tbl.push_back(mk(32'h7F0C, 0, 1, 32'h0, 0, 0, 2'd3, 32'h0));
        tbl.push_back(mk(32'h7F0C, 1, 0, 32'h9, 0, 0, 2'd3, 32'h0));
        tbl.push_back(mk(32'h7F10, 1, 0, 32'h77, 0, 1, 2'd0, 32'h0));
        tbl.push_back(mk(32'h7F18, 0, 1, 32'h0, 0, 0, 2'd2, TM1));
        tbl.push_back(mk(32'h7F1C, 1, 1, 32'h3, 0, 0, 2'd3, 32'h0));
        tbl.push_back(mk(32'h7EFC, 0, 1, 32'h0, 0, 0, 2'd3, 32'h0));
        tbl.push_back(mk(32'h7F14, 1, 1, 32'h12, 0, 1, 2'd1, TM1));
        tbl.push_back(mk(32'h7F40, 0, 1, 32'h0, 0, 0, 2'd0, 32'h0));
        tbl.push_back(mk(32'h0000, 0, 1, 32'h0, 0, 0, 2'd0, 32'h0));
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            PrAddr = tbl[i].baddr[31:2];
            PrWE   = tbl[i].we;
            PrRE   = tbl[i].re;
            PrWD   = tbl[i].wd;
            PrBE   = 4'hF;
            @(negedge clk);
            chk($sformatf("vec%0d", i), comb_act(),
                {25'b0, tbl[i].w0, tbl[i].w1, tbl[i].ta, 3'b000,
                 tbl[i].wd, tbl[i].rd});
        end
        @(posedge clk); #1;
        bus_idle();

        // device sequences
        dev_access(32'h7F24, 0, 1, 32'h0, 4'hF, 3, 32'hDEADBEEF, "ack3");
        dev_access(32'h7F20, 0, 1, 32'h0, 4'hF, 0, 32'h12345678, "tmo");
        dev_access(32'h7F28, 0, 1, 32'h0, 4'hF, TO, 32'hCAFEF00D, "ack16");
        dev_access(32'h7F3C, 1, 1, 32'h55AA, 4'h3, 5, 32'h1, "wr_both");
        dev_access(32'h7F30, 0, 1, 32'h0, 4'hF, TO + 1, 32'h9, "ack17");

        // stray ack while idle is ignored
        @(posedge clk); #1;
        dev_ack = 1'b1;
        PrAddr  = 30'h1FC0;
        PrRE    = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        dev_ack = 1'b0;
        bus_idle();
        @(negedge clk);
        chk("idle ack", {PrStall, dev_req, BusErr}, 3'b000);
        dev_access(32'h7F2C, 0, 1, 32'h0, 4'hF, 2, 32'hA5A5A5A5, "post");

        // reset in the middle of WAIT
        @(posedge clk); #1;
        PrAddr = 30'h1FCB;
        PrRE   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst mid-wait",
            {dev_req, PrStall, dev_addr, PrRD}, '0);
        @(posedge clk); #1;
        reset  = 1'b1;
        PrAddr = 30'h1FC0;
        PrRE   = 1'b1;
        @(negedge clk);
        chk("post-rst tm0", {PrStall, dev_req, PrRD}, {2'b00, TM0});
        @(posedge clk); #1;
        bus_idle();

        // randomized bus accesses
        for (int it = 0; it < 60; it++) begin
            b  = 32'h7EF0 + 4 * $urandom_range(0, 23);
            m  = $urandom_range(0, 3);
            we = (m == 1) || (m == 3);
            re = (m >= 2);
            wd = $urandom;
            be = 4'($urandom);
            if ((b >= 32'h7F20) && (b <= 32'h7F3F) && (we || re)) begin
                dev_access(b, we, re, wd, be, $urandom_range(0, 20),
                           $urandom, $sformatf("rnd%0d", it));
            end else begin
                @(posedge clk); #1;
                PrAddr = b[31:2];
                PrWE   = we;
                PrRE   = re;
                PrWD   = wd;
                PrBE   = be;
                @(negedge clk);
                chk($sformatf("rnd%0d comb", it), comb_act(),
                    model(b, we, re, wd));
            end
        end
        @(posedge clk); #1;
        bus_idle();
        repeat (SS + 1) @(posedge clk);

        // interrupt pulse
        #1;
        ext_int = 3'b010;
        tm1_irq = 1'b1;
        @(negedge clk);
        chk("irq now", HWInt, 6'b000010);
        for (int k = 1; k < SS; k++) begin
            @(posedge clk); #1;
            ext_int = 3'b000;
            @(negedge clk);
            chk($sformatf("irq lat%0d", k), HWInt, 6'b000010);
        end
        @(posedge clk); #1;
        ext_int = 3'b000;
        @(negedge clk);
        chk("irq synced", HWInt, 6'b010010);
        @(posedge clk);
        @(negedge clk);
`ifdef BRIDGE_EXT_EDGE_EN
        chk("irq held", HWInt, 6'b010010);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("irq still held", HWInt, 6'b010010);
        @(posedge clk); #1;
        PrAddr = 30'h1FD0;
        PrRE   = 1'b1;
        @(negedge clk);
        chk("pend read", PrRD, 32'h2);
        @(posedge clk); #1;
        PrRE   = 1'b0;
        PrWE   = 1'b1;
        PrBE   = 4'h1;
        PrWD   = 32'h2;
        @(negedge clk);
        chk("clr cycle", {PrStall, HWInt}, {1'b0, 6'b010010});
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk("cleared", HWInt, 6'b000010);
`else
        chk("irq dropped", HWInt, 6'b000010);
`endif

`ifndef BRIDGE_EXT_EDGE_EN
        // randomized level interrupts against a delay-line model
        for (int k = 0; k < SS; k++) hist.push_back(3'b000);
        for (int it = 0; it < 40; it++) begin
            @(posedge clk); #1;
            v       = 3'($urandom);
            ext_int = v;
            tm0_irq = 1'($urandom);
            tm1_irq = 1'($urandom);
            dev_irq = 1'($urandom);
            hist.push_back(v);
            @(negedge clk);
            chk($sformatf("irq rnd%0d", it), HWInt,
                {hist[hist.size() - 1 - SS], dev_irq, tm1_irq, tm0_irq});
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_bridge.md
Name: sys_bridge

Overview:
System bridge sitting directly downstream of the pipelined CPU datapath's M-stage bus (PrAddr/PrWD/PrBE/PrWE/PrRD/HWInt).
- Decodes CPU accesses to two single-cycle timers and one slow handshaked device.
- Inserts wait states for the slow device, with timeout.
- Collects and synchronises interrupt sources into the 6-bit HWInt vector consumed by CP0.

Parameters:
TIMEOUT, 16, cycles spent in WAIT without ack before the access is aborted (legal range 2..255)
SYNC_STAGES, 2, flop stages on each external interrupt input (legal range 2..3)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
PrAddr  input  30  CPU word address [31:2] from M stage
PrWD  input  32  CPU write data
PrBE  input  4  CPU byte enables
PrWE  input  1  CPU write strobe (M-stage store)
PrRE  input  1  CPU read strobe (M-stage load)
PrRD  output  32  read data returned to CPU
PrStall  output  1  freeze pipeline (to hazard unit)
BusErr  output  1  one-cycle pulse on slow-device timeout
HWInt  output  6  interrupt vector [7:2] to CP0
tm0_we, tm1_we  output  1 each  timer write enables
tm_addr  output  2  word offset within timer (PrAddr[3:2])
tm_wd  output  32  timer write data (=PrWD)
tm0_rd, tm1_rd  input  32 each  timer read data
tm0_irq, tm1_irq  input  1 each  timer interrupts (clk domain)
dev_req  output  1  slow-device request
dev_we  output  1  slow-device write
dev_addr  output  3  latched word offset (PrAddr[4:2])
dev_wd  output  32  latched write data
dev_be  output  4  latched byte enables
dev_ack  input  1  slow-device completion
dev_rd  input  32  slow-device read data, valid with dev_ack
dev_irq  input  1  slow-device interrupt (clk domain)
ext_int  input  3  asynchronous external interrupt lines

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-low.
- Address map (byte address = {PrAddr,2'b00}):
  - timer0: 0x7F00-0x7F0B
  - timer1: 0x7F10-0x7F1B
  - slow dev: 0x7F20-0x7F3F
  - anything else is unmapped.
- Timer accesses: combinational, zero wait.
  - tmX_we = PrWE & hit.
  - PrRD = tmX_rd when PrRE & hit.
- Unmapped accesses:
  - PrRD = 0; writes dropped; no stall; no BusErr.
- Slow-device FSM, states IDLE, WAIT, DONE:
  - IDLE: on dev hit & (PrWE|PrRE), PrStall=1 combinationally in that cycle. Latch addr/wd/be/we; next state WAIT.
  - WAIT: dev_req=1 with latched fields held stable; PrStall=1; timeout counter increments.
    - dev_ack -> capture dev_rd (reads) into rdata_q; next DONE.
    - Counter reaches TIMEOUT-1 without ack -> rdata_q=0, set err flag; next DONE.
    - ack in the same cycle as expiry: ack wins, no error.
  - DONE: dev_req=0; PrStall=0; PrRD=rdata_q; BusErr=err flag (one cycle); next IDLE unconditionally.
    - DONE never re-launches, even though the same instruction is still presented in M this cycle.
- PrWE and PrRE both high: treated as a write.
- dev_ack in IDLE or DONE is ignored.
- HWInt mapping:
  - [2] = tm0_irq, [3] = tm1_irq, [4] = dev_irq (passed through, no delay).
  - [7:5] = ext_int[2:0] after SYNC_STAGES flops, i.e. SYNC_STAGES cycles of latency, level-sensitive.
- Reset values, including reset mid-WAIT:
  - state=IDLE, counter=0, rdata_q=0, err=0, sync flops=0.
  - Outputs: dev_req=0, PrStall=0, BusErr=0, dev_we=0, dev_addr=0, dev_wd=0, dev_be=0.
  - PrRD=0; HWInt=combination of current tm/dev irqs with synced bits 0.

Optional Feature:
BRIDGE_EXT_EDGE_EN
- Defined:
  - ext_int bits latch on synchronised rising edge into pending[2:0]; HWInt[7:5]=pending.
  - Clear register at 0x7F40 (zero wait): write with PrBE[0]=1 clears pending bits where PrWD[2:0]=1.
  - Edge arriving in the same cycle as its clear: stays pending.
  - Read of 0x7F40 returns {29'b0,pending}.
- Undefined:
  - Level behaviour above; 0x7F40 is unmapped.

Test Plan:
- Reset, then write PrAddr=0x7F04>>2, PrWD=0x0000_0064, PrWE=1 -> tm0_we=1, tm_addr=1, tm_wd=0x64; PrStall=0; dev_req stays 0.
- Load from 0x7F24; dev_ack after 3 WAIT cycles with dev_rd=0xDEADBEEF -> PrStall high 4 cycles (IDLE + 3 WAIT); DONE cycle PrRD=0xDEADBEEF, BusErr=0; dev_addr=1 throughout.
- Load from 0x7F20, dev_ack never asserted, TIMEOUT=16 -> PrStall high 17 cycles; DONE gives PrRD=0 and a single-cycle BusErr=1; FSM back in IDLE.
- dev_ack asserted exactly on the 16th WAIT cycle -> ack wins: PrRD=dev_rd, BusErr=0.
- Assert reset during WAIT -> dev_req and PrStall drop immediately (asynchronous); after release, an access to 0x7F00 completes with no stall.
- ext_int=3'b010 pulse 1 cycle wide, tm1_irq=1 -> HWInt=6'b000010 immediately; HWInt[6] goes high SYNC_STAGES cycles later.
  - Without BRIDGE_EXT_EDGE_EN: HWInt[6] drops with the input.
  - With it: HWInt[6] holds until a write of 0x2 to 0x7F40.
